// File: rtl/memory_stage.sv
// MEM stage: word-organised single-port data memory plus the MEM/WB pipeline register.
// Define DMEM_RESET_CLEAR_EN to have reset asynchronously clear the whole data memory.

`ifndef BITS_REGFILE
`define BITS_REGFILE 4
`endif

module memory_stage #(
  parameter int AddrSize     = 32,
  parameter int DataWidth    = 32,
  parameter int MemDepthLog2 = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wreg_i,
  input  logic                     m2reg_i,
  input  logic                     wmem_i,
  input  logic [`BITS_REGFILE:0]   destination_i,
  input  logic [AddrSize-1:0]      aluresult_i,
  input  logic [DataWidth-1:0]     op2_i,
  output logic                     wreg_o,
  output logic                     m2reg_o,
  output logic [`BITS_REGFILE:0]   destination_o,
  output logic [AddrSize-1:0]      aluresult_o,
  output logic [DataWidth-1:0]     dmemout_o
);

  localparam int Depth = 1 << MemDepthLog2;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  logic [MemDepthLog2-1:0] word_idx;
  logic [DataWidth-1:0]    mem [Depth];
  logic [DataWidth-1:0]    rd_data;

  assign word_idx = aluresult_i[MemDepthLog2+1:2];

  // Write-first: a store in the same cycle returns the data being stored.
  always_comb begin
    rd_data = mem[word_idx];
    if (wmem_i) begin
      rd_data = op2_i;
    end
  end

`ifdef DMEM_RESET_CLEAR_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wmem_i) begin
      mem[word_idx] <= op2_i;
    end
  end
`else
  // No reset on the array so it maps onto RAM; an edge seen during reset writes nothing.
  always_ff @(posedge clk_i) begin
    if (rst_i && wmem_i) begin
      mem[word_idx] <= op2_i;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wreg_o        <= 1'b0;
      m2reg_o       <= 1'b0;
      destination_o <= '0;
      aluresult_o   <= '0;
      dmemout_o     <= '0;
    end else begin
      wreg_o        <= wreg_i;
      m2reg_o       <= m2reg_i;
      destination_o <= destination_i;
      aluresult_o   <= aluresult_i;
      dmemout_o     <= rd_data;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table, reset sequences and randomized traffic vs a word-map model.

`ifndef BITS_REGFILE
`define BITS_REGFILE 4
`endif

module tb_memory_stage;

  localparam int DEPTH = 256;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   wreg_i, m2reg_i, wmem_i;
  logic [`BITS_REGFILE:0] destination_i;
  logic [31:0]            aluresult_i, op2_i;
  logic                   wreg_o, m2reg_o;
  logic [`BITS_REGFILE:0] destination_o;
  logic [31:0]            aluresult_o, dmemout_o;

  memory_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wreg_i(wreg_i), .m2reg_i(m2reg_i), .wmem_i(wmem_i),
    .destination_i(destination_i), .aluresult_i(aluresult_i), .op2_i(op2_i),
    .wreg_o(wreg_o), .m2reg_o(m2reg_o), .destination_o(destination_o),
    .aluresult_o(aluresult_o), .dmemout_o(dmemout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference memory: word index -> last stored value; absent means never written.
  logic [31:0] mdl [int];
  bit          mdl_cleared = 0;

  typedef struct {
    logic        wreg, m2reg, wmem;
    logic [4:0]  dest;
    logic [31:0] alu, op2;
    logic [31:0] exp_dmem;
    bit          chk_dmem;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic w, input logic m, input logic [4:0] d,
                            input logic [31:0] a, input logic [31:0] dm, input bit chk_dm);
    check({tag, ".wreg_o"}, {31'd0, wreg_o}, {31'd0, w});
    check({tag, ".m2reg_o"}, {31'd0, m2reg_o}, {31'd0, m});
    check({tag, ".destination_o"}, {27'd0, destination_o}, {27'd0, d});
    check({tag, ".aluresult_o"}, aluresult_o, a);
    if (chk_dm) check({tag, ".dmemout_o"}, dmemout_o, dm);
  endtask

  task automatic drive(input logic w, input logic m, input logic wm, input logic [4:0] d,
                       input logic [31:0] a, input logic [31:0] o);
    wreg_i = w; m2reg_i = m; wmem_i = wm; destination_i = d; aluresult_i = a; op2_i = o;
  endtask

  task automatic drive_random();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Expected read value for the currently driven inputs; also commits any store.
  function automatic bit model_access(output logic [31:0] val);
    int idx = word_of(aluresult_i);
    bit known;
    if (wmem_i) begin
      val = op2_i;
      known = 1;
      mdl[idx] = op2_i;
    end else if (mdl.exists(idx)) begin
      val = mdl[idx];
      known = 1;
    end else begin
      val = 32'd0;
      known = mdl_cleared;
    end
    return known;
  endfunction

  function automatic void model_reset();
`ifdef DMEM_RESET_CLEAR_EN
    mdl.delete();
    mdl_cleared = 1;
`endif
  endfunction

  task automatic add_vec(input logic w, input logic m, input logic wm, input logic [4:0] d,
                         input logic [31:0] a, input logic [31:0] o, input logic [31:0] e, input bit c);
    vec_t v;
    v.wreg = w; v.m2reg = m; v.wmem = wm; v.dest = d; v.alu = a; v.op2 = o;
    v.exp_dmem = e; v.chk_dmem = c;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_dm;
    bit          known;
    logic        pw, pm;
    logic [4:0]  pd;
    logic [31:0] pa;

    // Directed vectors: each row's outputs are checked right after its own edge.
    add_vec(0, 0, 1, 0,  32'h10,       32'hDEADBEEF, 32'hDEADBEEF, 1);
    add_vec(1, 1, 0, 5,  32'h10,       32'h0,        32'hDEADBEEF, 1);
    add_vec(0, 0, 1, 3,  32'h20,       32'h12345678, 32'h12345678, 1);
    add_vec(0, 0, 1, 0,  32'h40,       32'hA5A5A5A5, 32'hA5A5A5A5, 1);
    add_vec(1, 1, 0, 9,  32'h43,       32'h0,        32'hA5A5A5A5, 1);
    add_vec(1, 1, 0, 9,  32'h440,      32'h0,        32'hA5A5A5A5, 1);
    add_vec(1, 0, 0, 31, 32'hFFFFFFFF, 32'h77777777, 32'h0,        0);
    add_vec(0, 1, 0, 2,  32'h20,       32'h0,        32'h12345678, 1);
    add_vec(0, 1, 0, 2,  32'h10,       32'h0,        32'hDEADBEEF, 1);
    add_vec(0, 0, 1, 1,  32'h3FC,      32'hCAFEF00D, 32'hCAFEF00D, 1);
    add_vec(1, 1, 0, 4,  32'hFFFFFFFC, 32'h0,        32'hCAFEF00D, 1);
    add_vec(1, 1, 0, 4,  32'h41,       32'h0,        32'hA5A5A5A5, 1);

    // Reset held with inputs toggling: outputs stay zero, stores suppressed.
    rst_i = 1'b0;
    drive_random();
    #1;
    model_reset();
    check_outs("reset_async", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_outs($sformatf("reset_hold%0d", i), 0, 0, 0, 0, 0, 1);
      drive_random();
    end
    rst_i = 1'b1;

    // First edge after release: outputs follow inputs.
    drive(1, 0, 0, 5'd17, 32'h0000_1234, 32'h0);
    known = model_access(exp_dm);
    step();
    check_outs("release", 1, 0, 5'd17, 32'h1234, exp_dm, known);

    foreach (vecs[i]) begin
      drive(vecs[i].wreg, vecs[i].m2reg, vecs[i].wmem, vecs[i].dest, vecs[i].alu, vecs[i].op2);
      known = model_access(exp_dm);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].wreg, vecs[i].m2reg, vecs[i].dest,
                 vecs[i].alu, vecs[i].exp_dmem, vecs[i].chk_dmem);
    end

    // Reset persistence: 0x55 stored at 0x8 survives a reset pulse unless clearing is enabled.
    drive(0, 0, 1, 0, 32'h8, 32'h55);
    known = model_access(exp_dm);
    step();
    check_outs("persist_wr", 0, 0, 0, 32'h8, 32'h55, 1);
    drive(1, 1, 1, 5'd6, 32'h8, 32'h99);
    #3;
    rst_i = 1'b0;
    #1;
    check_outs("persist_rst_async", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_outs($sformatf("persist_rst%0d", i), 0, 0, 0, 0, 0, 1);
    end
    model_reset();
    rst_i = 1'b1;
    drive(1, 1, 0, 5'd7, 32'h8, 32'h0);
    known = model_access(exp_dm);
    step();
`ifdef DMEM_RESET_CLEAR_EN
    check_outs("persist_rd", 1, 1, 5'd7, 32'h8, 32'h0, 1);
`else
    check_outs("persist_rd", 1, 1, 5'd7, 32'h8, 32'h55, 1);
`endif

    // Randomized traffic concentrated on 16 words, with junk in byte-offset and wrap bits.
    for (int i = 0; i < 400; i++) begin
      pw = 1'($urandom);
      pm = 1'($urandom);
      pd = 5'($urandom);
      pa = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      drive(pw, pm, ($urandom_range(0, 2) == 0), pd, pa, $urandom);
      known = model_access(exp_dm);
      step();
      check_outs($sformatf("rand%0d", i), pw, pm, pd, pa, exp_dm, known);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
